channel_noise_injector: RTL and testbench

Parametrised discrete-noise injector for the Rx simulation channel. Draws a 64-bit uniform random word per accepted sample, maps it through a programmable cumulative threshold table to one of NUM_LEVELS signed noise levels, scales the level by a runtime gain, and adds it to the incoming sample with saturation. It sits between the channel model and the Rx front end, with valid/ready handshakes on both sides and a saturation-event counter for BER bookkeeping.

---
 rtl/channel_noise_injector_pkg.sv | 33 +++
 rtl/channel_noise_injector_urng.sv | 39 +++
 rtl/channel_noise_injector.sv | 156 +++++++++++++++
 tb/tb_channel_noise_injector.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_noise_injector_pkg.sv
// Shared definitions for the channel noise injector: table-select encodings,
// default gain and the clamping adder used on the output stage.
package channel_noise_injector_pkg;

    typedef enum logic {
        CFG_THR = 1'b0,
        CFG_LVL = 1'b1
    } cfg_sel_e;

    localparam int unsigned DEFAULT_GAIN = 28;

    // Adds two wide signed values and clamps the result to a signed w-bit range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            sat_add = hi;
        end else if (s < lo) begin
            sat_add = lo;
        end else begin
            sat_add = s;
        end
    endfunction

endpackage

// File: rtl/channel_noise_injector_urng.sv
// 64-bit uniform random source (xorshift64). The state advances only when en
// is high, so the consumer sees a fresh word for every pulse.
module urng_64 #(
    parameter logic [63:0] SEED = 64'h9E37_79B9_7F4A_7C15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic [63:0] data_out,
    output logic        valid
);

    logic [63:0] state_q;
    logic [63:0] state_d;
    logic        valid_q;

    always_comb begin
        state_d = state_q;
        state_d = state_d ^ (state_d << 13);
        state_d = state_d ^ (state_d >> 7);
        state_d = state_d ^ (state_d << 17);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SEED;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (en) begin
                state_q <= state_d;
            end
        end
    end

    assign data_out = state_q;
    assign valid    = valid_q;

endmodule

// File: rtl/channel_noise_injector.sv
// Discrete-noise injector: random draw -> cumulative-threshold level select ->
// gain scaling -> saturating add onto the sample, in a two-stage pipeline.
module channel_noise_injector
    import channel_noise_injector_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_LEVELS = 4,
    parameter int GAIN_W     = 8,
    parameter int GAIN_FRAC  = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          bypass,
    input  logic [GAIN_W-1:0]             gain,
    input  logic                          cfg_we,
    input  logic                          cfg_sel,
    input  logic [$clog2(NUM_LEVELS)-1:0] cfg_addr,
    input  logic [63:0]                   cfg_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic [CNT_W-1:0]              sat_count,
    input  logic                          sat_clr
);

    localparam int AW = $clog2(NUM_LEVELS);
    localparam int PW = DATA_W + GAIN_W + 1;

    logic [NUM_LEVELS-1:0][63:0]     thr_q;
    logic [NUM_LEVELS-1:0][DATA_W-1:0] lvl_q;

    logic [63:0] rnd;
    logic        rng_valid;
    logic        rng_rstn;
    logic        accept;
    logic        adv1;
    logic        adv2;

    logic [AW-1:0] hit_idx;
    logic          hit;

    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] s1_data_q;
    logic signed [DATA_W-1:0] s1_lvl_q;
    logic [GAIN_W-1:0]        s1_gain_q;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] noise;
    logic signed [63:0]   sum_raw;
    logic signed [63:0]   sum_sat;
    logic                 sat_hit;

    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic [CNT_W-1:0]         sat_cnt_q;
    logic [CNT_W-1:0]         sat_cnt_d;

    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = en && rng_valid && adv1;
    assign accept   = in_valid && in_ready;
    assign rng_rstn = ~rst;

    urng_64 u_rng (
        .clk      (clk),
        .rstn     (rng_rstn),
        .en       (accept),
        .data_out (rnd),
        .valid    (rng_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q <= '0;
            lvl_q <= '0;
        end else if (cfg_we && (int'(cfg_addr) < NUM_LEVELS)) begin
            if (cfg_sel == CFG_THR) begin
                thr_q[cfg_addr] <= cfg_data;
            end else begin
                lvl_q[cfg_addr] <= cfg_data[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (rnd < thr_q[i]) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    // The selected level is snapshotted at acceptance so later table writes
    // never reach a sample already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_lvl_q   <= '0;
            s1_gain_q  <= '0;
        end else if (adv1) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_data_q <= in_data;
                s1_gain_q <= gain;
                s1_lvl_q  <= (hit && !bypass) ? $signed(lvl_q[hit_idx]) : '0;
            end
        end
    end

    always_comb begin
        prod    = PW'(s1_lvl_q) * PW'($signed({1'b0, s1_gain_q}));
        noise   = prod >>> GAIN_FRAC;
        sum_raw = 64'(s1_data_q) + 64'(noise);
        sum_sat = sat_add(64'(s1_data_q), 64'(noise), DATA_W);
        sat_hit = (sum_sat != sum_raw);
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (adv2 && s1_valid_q && sat_hit && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_cnt_q   <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= sum_sat[DATA_W-1:0];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_channel_noise_injector.sv
// Scoreboard bench for channel_noise_injector: expected outputs are queued at
// acceptance and compared as the DUT delivers them.
module tb_channel_noise_injector;

    localparam int DATA_W     = 8;
    localparam int NUM_LEVELS = 4;
    localparam int GAIN_W     = 8;
    localparam int GAIN_FRAC  = 0;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              bypass;
    logic [7:0]        gain;
    logic              cfg_we;
    logic              cfg_sel;
    logic [1:0]        cfg_addr;
    logic [63:0]       cfg_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [15:0]       sat_count;
    logic              sat_clr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_tx     = 0;
    int n_rx     = 0;
    int sat_exp  = 0;
    int model_lvl = 0;
    int e_pop;
    int c_zero = 0, c_pos = 0, c_neg = 0, c_other = 0;
    bit mon_on   = 1'b1;
    bit mon_hist = 1'b0;
    bit bp_en    = 1'b0;
    int exp_q[$];

    channel_noise_injector #(
        .DATA_W     (DATA_W),
        .NUM_LEVELS (NUM_LEVELS),
        .GAIN_W     (GAIN_W),
        .GAIN_FRAC  (GAIN_FRAC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bypass    (bypass),
        .gain      (gain),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic cfg_write(input bit sel, input int addr, input logic [63:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 2'(addr); cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input int d, input int g);
        int lvl, s, e, t;
        bit acc;
        lvl = bypass ? 0 : model_lvl;
        s = d + ((lvl * g) >>> GAIN_FRAC);
        e = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        in_valid = 1'b1; in_data = 8'(d); gain = 8'(g);
        acc = 1'b0; t = 0;
        while (!acc && t < 1000) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else t++;
        end
        if (acc) begin
            n_tx++;
            if (!mon_hist) exp_q.push_back(e);
            if (e != s) sat_exp++;
        end else begin
            chk("accept_timeout", acc, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((n_rx != n_tx) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (n_rx != n_tx) chk("drain_timeout", n_rx, n_tx);
    endtask

    always @(negedge clk) begin
        if (!rst && mon_on && out_valid && out_ready) begin
            n_rx++;
            if (mon_hist) begin
                if (out_data == 8'sd0) c_zero++;
                else if (out_data == 8'sd28) c_pos++;
                else if (out_data == -8'sd28) c_neg++;
                else c_other++;
            end else if (exp_q.size() == 0) begin
                chk("sb_extra_output", n_rx, n_tx);
            end else begin
                e_pop = exp_q.pop_front();
                chk("sb_data", out_data, e_pop);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = ($urandom_range(0, 99) >= 30);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; bypass = 1'b0; gain = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // pass-through from reset tables and two-cycle latency
        send(10, 0);
        @(negedge clk);
        chk("lat_not_yet_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_data", out_data, 10);
        @(posedge clk); #1;
        drain();
        chk("lat_sat_count", sat_count, 0);

        // positive and negative saturation, then clear
        cfg_write(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_write(1, 0, 64'd100);
        model_lvl = 100;
        for (int i = 0; i < 5; i++) send(100, 1);
        drain();
        chk("sat_pos_count", sat_count, sat_exp);
        cfg_write(1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        model_lvl = -1;
        for (int i = 0; i < 3; i++) send(-128, 1);
        drain();
        chk("sat_neg_count", sat_count, sat_exp);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        sat_exp = 0;
        chk("sat_clr", sat_count, 0);

        // level write coincident with acceptance uses the old level
        cfg_write(1, 0, 64'd7);
        model_lvl = 7;
        in_valid = 1'b1; in_data = 8'sd0; gain = 8'd1;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 2'd0; cfg_data = 64'd20;
        @(negedge clk);
        chk("coinc_in_ready", in_ready, 1);
        if (in_ready) begin
            n_tx++;
            exp_q.push_back(7);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        model_lvl = 20;
        send(0, 1);
        drain();

        // both stages full and stalled
        out_ready = 1'b0;
        send(1, 1);
        send(2, 1);
        in_valid = 1'b1; in_data = 8'sd3; gain = 8'd1;
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, 21);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", out_data, 21);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // random backpressure against the golden model
        cfg_write(1, 0, 64'd5);
        model_lvl = 5;
        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) send($urandom_range(0, 255) - 128, $urandom_range(0, 40));
        drain();
        bp_en = 1'b0;
        out_ready = 1'b1;
        chk("bp_exp_q_empty", exp_q.size(), 0);
        chk("bp_sat_count", sat_count, sat_exp);

        // level distribution
        cfg_write(0, 0, 64'h7FFF_FFFF_FFFF_FFFF);
        cfg_write(0, 1, 64'hBFFF_FFFF_FFFF_FFFF);
        cfg_write(0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_write(0, 3, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_write(1, 0, 64'd0);
        cfg_write(1, 1, 64'd1);
        cfg_write(1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_write(1, 3, 64'd0);
        mon_hist = 1'b1;
        for (int i = 0; i < 10000; i++) send(0, 28);
        drain();
        mon_hist = 1'b0;
        chk("dist_other", c_other, 0);
        chk("dist_zero_ratio", (c_zero >= 4800 && c_zero <= 5200), 1);
        chk("dist_pos_ratio", (c_pos >= 2300 && c_pos <= 2700), 1);
        chk("dist_neg_ratio", (c_neg >= 2300 && c_neg <= 2700), 1);
        chk("dist_total", c_zero + c_pos + c_neg + c_other, 10000);

        // bypass, then all-miss tables
        cfg_write(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_write(1, 0, 64'd50);
        model_lvl = 50;
        bypass = 1'b1;
        send(-128, 10); send(-1, 10); send(0, 10); send(1, 10); send(127, 10);
        drain();
        bypass = 1'b0;
        for (int i = 0; i < 4; i++) cfg_write(0, i, 64'd0);
        model_lvl = 0;
        send(-128, 10); send(-1, 10); send(0, 10); send(1, 10); send(127, 10);
        drain();

        // reset with two samples in flight
        cfg_write(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_write(1, 0, 64'd7);
        model_lvl = 7;
        mon_on = 1'b0;
        send(10, 1);
        send(20, 1);
        chk("pre_rst_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_sat_count", sat_count, 0);
        chk("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        n_tx = 0; n_rx = 0; sat_exp = 0; model_lvl = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1'b1;
        send(10, 50); send(-20, 50); send(30, 50);
        drain();
        chk("post_rst_sat_count", sat_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
